// File: rtl/seg7_pkg.sv
// Segment encoding shared by the BCD-to-segment decoder and the scan reader.
// Segments are active-low; bit 6 is segment a down to bit 0 for segment g.
package seg7_pkg;

    typedef enum logic [2:0] {
        SEG_G = 3'd0,
        SEG_F = 3'd1,
        SEG_E = 3'd2,
        SEG_D = 3'd3,
        SEG_C = 3'd4,
        SEG_B = 3'd5,
        SEG_A = 3'd6
    } seg_bit_e;

    localparam logic [6:0] SEG_0     = 7'h01;
    localparam logic [6:0] SEG_1     = 7'h4F;
    localparam logic [6:0] SEG_2     = 7'h12;
    localparam logic [6:0] SEG_3     = 7'h06;
    localparam logic [6:0] SEG_4     = 7'h4C;
    localparam logic [6:0] SEG_5     = 7'h24;
    localparam logic [6:0] SEG_6     = 7'h20;
    localparam logic [6:0] SEG_7     = 7'h0F;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h04;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] CODE_BLANK   = 4'hA;
    localparam logic [3:0] CODE_INVALID = 4'hF;

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// Inverse of the BCD-to-segment decoder: maps an active-low segment pattern
// back to its digit code, with blank and invalid patterns given reserved codes.
module seg7_pattern_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       err
);

    always_comb begin
        case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: code = CODE_BLANK;
            default:   code = CODE_INVALID;
        endcase
    end

    // No legal pattern decodes to CODE_INVALID, so the code alone carries the error.
    assign err = (code == CODE_INVALID);

endmodule

// File: rtl/seg7_scan_reader.sv
// Reads a multiplexed active-low seven-segment bus back into BCD frames and
// publishes a frame once it has been seen identically for STABLE_SCANS scans.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SETTLE       = 2,
    parameter int STABLE_SCANS = 2
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     an,
    input  logic [6:0]            seg,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     err_out,
    output logic                  out_valid
);

    localparam int CNT_W = $clog2(SETTLE + 1);
    localparam int STB_W = $clog2(STABLE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(SETTLE);
    localparam logic [STB_W-1:0] STB_MAX = STB_W'(STABLE_SCANS);

    logic [3:0]          live_code;
    logic                live_err;
    logic                onehot;
    logic                capture;
    logic                same_frame;

    logic [DIGITS-1:0]   an_prev_q, an_prev_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DIGITS-1:0]   mask_q, mask_d;
    logic [4*DIGITS-1:0] frame_code_q, frame_code_d;
    logic [DIGITS-1:0]   frame_err_q, frame_err_d;
    logic                complete_q, complete_d;
    logic [4*DIGITS-1:0] prev_code_q, prev_code_d;
    logic [DIGITS-1:0]   prev_err_q, prev_err_d;
    logic [STB_W-1:0]    stable_q, stable_d;
    logic                published_q, published_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]   err_q, err_d;
    logic                valid_q, valid_d;

    seg7_pattern_to_bcd u_decode (
        .seg  (seg),
        .code (live_code),
        .err  (live_err)
    );

    always_comb begin
        an_prev_d    = an;
        cnt_d        = '0;
        mask_d       = mask_q;
        frame_code_d = frame_code_q;
        frame_err_d  = frame_err_q;
        prev_code_d  = prev_code_q;
        prev_err_d   = prev_err_q;
        stable_d     = stable_q;
        published_d  = published_q;
        bcd_d        = bcd_q;
        err_d        = err_q;
        valid_d      = 1'b0;
        same_frame   = 1'b0;

        // Saturating above SETTLE-1 makes the capture point occur once per dwell.
        onehot = $onehot(~an);
        if (onehot && (an == an_prev_q)) begin
            cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        end
        capture = onehot && (cnt_d == CNT_CAP);

        if (complete_q) begin
            // stable_q is zero only when no frame has been seen since reset.
            same_frame = (stable_q != '0) && (frame_code_q == prev_code_q)
                         && (frame_err_q == prev_err_q);
            if (same_frame) begin
                stable_d = (stable_q == STB_MAX) ? stable_q : stable_q + 1'b1;
            end else begin
                stable_d = STB_W'(1);
            end
            prev_code_d = frame_code_q;
            prev_err_d  = frame_err_q;
            if ((stable_d == STB_MAX) && !valid_q
                && (!published_q || (frame_code_q != bcd_q) || (frame_err_q != err_q))) begin
                bcd_d       = frame_code_q;
                err_d       = frame_err_q;
                valid_d     = 1'b1;
                published_d = 1'b1;
            end
            mask_d = '0;
        end

        // Applied after the clear so a capture in the evaluation cycle opens the next frame.
        for (int i = 0; i < DIGITS; i++) begin
            if (capture && !an[i]) begin
                mask_d[i]              = 1'b1;
                frame_code_d[4*i +: 4] = live_code;
                frame_err_d[i]         = live_err;
            end
        end

        complete_d = &mask_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_prev_q    <= '1;
            cnt_q        <= '0;
            mask_q       <= '0;
            frame_code_q <= '0;
            frame_err_q  <= '0;
            complete_q   <= 1'b0;
            prev_code_q  <= '0;
            prev_err_q   <= '0;
            stable_q     <= '0;
            published_q  <= 1'b0;
            bcd_q        <= '0;
            err_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            an_prev_q    <= an_prev_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            frame_code_q <= frame_code_d;
            frame_err_q  <= frame_err_d;
            complete_q   <= complete_d;
            prev_code_q  <= prev_code_d;
            prev_err_q   <= prev_err_d;
            stable_q     <= stable_d;
            published_q  <= published_d;
            bcd_q        <= bcd_d;
            err_q        <= err_d;
            valid_q      <= valid_d;
        end
    end

    assign bcd_out   = bcd_q;
    assign err_out   = err_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: drives dwells on the display bus and compares
// published frames against a dwell-level model of the reader.
module tb_seg7_scan_reader;

    localparam int DIGITS       = 4;
    localparam int SETTLE       = 2;
    localparam int STABLE_SCANS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  an  = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic [15:0] bcd_out;
    logic [3:0]  err_out;
    logic        out_valid;

    seg7_scan_reader #(
        .DIGITS       (DIGITS),
        .SETTLE       (SETTLE),
        .STABLE_SCANS (STABLE_SCANS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .an        (an),
        .seg       (seg),
        .bcd_out   (bcd_out),
        .err_out   (err_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] t;
        logic [15:0] bcd;
        logic [3:0]  err;
    } pulse_t;

    pulse_t obs_q[$];
    pulse_t exp_q[$];
    int     n_vec = 0;
    int     n_err = 0;
    int     dbl   = 0;
    logic   ov_prev = 1'b0;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            obs_q.push_back(pulse_t'{t: 32'(cyc), bcd: bcd_out, err: err_out});
            if (ov_prev) dbl++;
        end
        ov_prev = (out_valid === 1'b1);
    end

    // Reference model: digit patterns from the display table, frames assembled per capture.
    logic [6:0]  pat [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};
    logic [3:0]  m_mask;
    logic [15:0] m_code, m_prev_code, m_pub_code;
    logic [3:0]  m_err, m_prev_err, m_pub_err;
    int          m_stable;
    bit          m_have_prev, m_published;

    task automatic model_reset();
        m_mask = 0; m_code = 0; m_err = 0; m_prev_code = 0; m_prev_err = 0;
        m_stable = 0; m_have_prev = 0; m_published = 0; m_pub_code = 0; m_pub_err = 0;
    endtask

    task automatic model_capture(input int d, input logic [6:0] s, input int t);
        logic [3:0] c;
        logic       e;
        bit         same;
        c = 4'hF;
        e = 1'b1;
        for (int k = 0; k < 10; k++) if (s == pat[k]) begin c = 4'(k); e = 1'b0; end
        if (s == 7'h7F) begin c = 4'hA; e = 1'b0; end
        m_code[4*d +: 4] = c;
        m_err[d]  = e;
        m_mask[d] = 1'b1;
        if (m_mask == 4'hF) begin
            same = m_have_prev && (m_code == m_prev_code) && (m_err == m_prev_err);
            if (same) m_stable = (m_stable < STABLE_SCANS) ? m_stable + 1 : STABLE_SCANS;
            else      m_stable = 1;
            m_prev_code = m_code;
            m_prev_err  = m_err;
            m_have_prev = 1;
            if (m_stable == STABLE_SCANS &&
                (!m_published || m_code != m_pub_code || m_err != m_pub_err)) begin
                exp_q.push_back(pulse_t'{t: 32'(t + 2), bcd: m_code, err: m_err});
                m_published = 1;
                m_pub_code  = m_code;
                m_pub_err   = m_err;
            end
            m_mask = 0;
        end
    endtask

    task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int len);
        int start;
        start = cyc;
        an  = a;
        seg = s;
        repeat (len) begin @(posedge clk); #1; end
        if ($onehot(~a) && len >= SETTLE)
            for (int i = 0; i < DIGITS; i++) if (!a[i]) model_capture(i, s, start + SETTLE - 1);
    endtask

    task automatic scan(input logic [6:0] p3, p2, p1, p0, input int len);
        dwell(4'b0111, p3, len);
        dwell(4'b1011, p2, len);
        dwell(4'b1101, p1, len);
        dwell(4'b1110, p0, len);
    endtask

    task automatic idle(input int len);
        dwell(4'hF, 7'h7F, len);
    endtask

    task automatic do_reset();
        rst = 1'b1; an = 4'hF; seg = 7'h7F;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            an  = 4'($urandom);
            seg = 7'($urandom);
            @(negedge clk);
            n_vec++;
            if (bcd_out !== 16'h0 || err_out !== 4'h0 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold got bcd=%h err=%b vld=%b want 0000/0000/0", bcd_out, err_out, out_valid);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; an = 4'hF; seg = 7'h7F;
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++;
        if (bcd_out !== 16'h0 || err_out !== 4'h0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release got bcd=%h err=%b vld=%b want 0000/0000/0", bcd_out, err_out, out_valid);
        end
        @(posedge clk); #1;
        model_reset();
        obs_q.delete();
    endtask

    task automatic test_stable();
        pulse_t o, e;
        scan(7'h4F, 7'h12, 7'h06, 7'h4C, 4);
        scan(7'h4F, 7'h12, 7'h06, 7'h4C, 4);
        idle(4);
        n_vec++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_err++;
            $display("FAIL stable_count got %0d pulses want 1 (model %0d)", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL stable_pulse got t=%0d bcd=%h err=%b want t=%0d bcd=%h err=%b", o.t, o.bcd, o.err, e.t, e.bcd, e.err);
            end
        end
        obs_q.delete(); exp_q.delete();
        n_vec++;
        if (bcd_out !== 16'h1234 || err_out !== 4'h0) begin
            n_err++;
            $display("FAIL stable_value got bcd=%h err=%b want 1234/0000", bcd_out, err_out);
        end
    endtask

    task automatic test_back_to_back();
        scan(7'h4F, 7'h12, 7'h06, 7'h4C, 4);
        scan(7'h4F, 7'h12, 7'h06, 7'h4C, 3);
        idle(4);
        n_vec++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL repeat_nopulse got %0d pulses want 0 (model %0d)", obs_q.size(), exp_q.size());
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_transient();
        scan(7'h24, 7'h20, 7'h0F, 7'h00, 4);
        scan(7'h4F, 7'h12, 7'h06, 7'h4C, 4);
        scan(7'h4F, 7'h12, 7'h06, 7'h4C, 4);
        idle(4);
        n_vec++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL transient_nopulse got %0d pulses want 0 (model %0d)", obs_q.size(), exp_q.size());
        end
        obs_q.delete(); exp_q.delete();
        n_vec++;
        if (bcd_out !== 16'h1234) begin
            n_err++;
            $display("FAIL transient_hold got bcd=%h want 1234", bcd_out);
        end
    endtask

    task automatic test_invalid();
        pulse_t o, e;
        scan(7'h04, 7'h7E, 7'h04, 7'h7F, 4);
        scan(7'h04, 7'h7E, 7'h04, 7'h7F, 4);
        idle(4);
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL invalid_count got %0d pulses want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL invalid_pulse got t=%0d bcd=%h err=%b want t=%0d bcd=%h err=%b", o.t, o.bcd, o.err, e.t, e.bcd, e.err);
            end
        end
        obs_q.delete(); exp_q.delete();
        n_vec++;
        if (bcd_out !== 16'h9F9A || err_out !== 4'b0100) begin
            n_err++;
            $display("FAIL invalid_value got bcd=%h err=%b want 9f9a/0100", bcd_out, err_out);
        end
    endtask

    task automatic test_glitch();
        pulse_t o, e;
        for (int r = 0; r < 3; r++)
            for (int d = 3; d >= 0; d--) dwell(~(4'b1 << d), 7'($urandom), 1);
        idle(3);
        n_vec++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL glitch_short got %0d pulses want 0 (model %0d)", obs_q.size(), exp_q.size());
        end
        dwell(4'b0000, 7'h4F, 4);
        dwell(4'b1111, 7'h12, 4);
        scan(7'h4C, 7'h06, 7'h12, 7'h4F, 4);
        dwell(4'b0000, 7'h06, 3);
        scan(7'h4C, 7'h06, 7'h12, 7'h4F, 4);
        idle(4);
        n_vec++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_err++;
            $display("FAIL glitch_count got %0d pulses want 1 (model %0d)", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL glitch_pulse got t=%0d bcd=%h err=%b want t=%0d bcd=%h err=%b", o.t, o.bcd, o.err, e.t, e.bcd, e.err);
            end
        end
        obs_q.delete(); exp_q.delete();
        n_vec++;
        if (bcd_out !== 16'h4321) begin
            n_err++;
            $display("FAIL glitch_value got bcd=%h want 4321", bcd_out);
        end
    endtask

    task automatic test_mid_reset();
        pulse_t o, e;
        scan(7'h4F, 7'h12, 7'h06, 7'h4C, 4);
        dwell(4'b0111, 7'h4F, 4);
        dwell(4'b1011, 7'h12, 4);
        do_reset();
        @(negedge clk);
        n_vec++;
        if (bcd_out !== 16'h0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_clear got bcd=%h vld=%b want 0000/0", bcd_out, out_valid);
        end
        @(posedge clk); #1;
        scan(7'h4F, 7'h12, 7'h06, 7'h4C, 4);
        idle(3);
        n_vec++;
        if (obs_q.size() != 0) begin
            n_err++;
            $display("FAIL midreset_early got %0d pulses want 0", obs_q.size());
        end
        scan(7'h4F, 7'h12, 7'h06, 7'h4C, 4);
        idle(4);
        n_vec++;
        if (obs_q.size() != 1 || exp_q.size() != 1) begin
            n_err++;
            $display("FAIL midreset_count got %0d pulses want 1 (model %0d)", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL midreset_pulse got t=%0d bcd=%h err=%b want t=%0d bcd=%h err=%b", o.t, o.bcd, o.err, e.t, e.bcd, e.err);
            end
        end
        obs_q.delete(); exp_q.delete();
        n_vec++;
        if (bcd_out !== 16'h1234) begin
            n_err++;
            $display("FAIL midreset_value got bcd=%h want 1234", bcd_out);
        end
    endtask

    function automatic logic [6:0] rand_pat();
        int r;
        r = $urandom_range(0, 9);
        if (r < 8)  return pat[$urandom_range(0, 9)];
        if (r == 8) return 7'h7F;
        return 7'($urandom);
    endfunction

    task automatic test_random();
        pulse_t     o, e;
        logic [6:0] p [4];
        logic [3:0] g;
        for (int r = 0; r < 40; r++) begin
            for (int d = 0; d < 4; d++) p[d] = rand_pat();
            for (int s = 0, ns = $urandom_range(1, 3); s < ns; s++) begin
                for (int d = 3; d >= 0; d--) begin
                    if ($urandom_range(0, 7) == 0) begin
                        case ($urandom_range(0, 2))
                            0:       g = 4'b0000;
                            1:       g = 4'b1111;
                            default: g = 4'b0101;
                        endcase
                        dwell(g, 7'($urandom), $urandom_range(1, 3));
                    end
                    dwell(~(4'b1 << d), p[d], $urandom_range(1, 5));
                end
            end
        end
        idle(4);
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL random_count got %0d pulses want %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL random_pulse got t=%0d bcd=%h err=%b want t=%0d bcd=%h err=%b", o.t, o.bcd, o.err, e.t, e.bcd, e.err);
            end
        end
        obs_q.delete(); exp_q.delete();
        n_vec++;
        if (bcd_out !== m_pub_code || err_out !== m_pub_err) begin
            n_err++;
            $display("FAIL random_final got bcd=%h err=%b want bcd=%h err=%b", bcd_out, err_out, m_pub_code, m_pub_err);
        end
        n_vec++;
        if (dbl != 0) begin
            n_err++;
            $display("FAIL valid_back_to_back got %0d adjacent pulses want 0", dbl);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stable();
        test_back_to_back();
        test_transient();
        test_invalid();
        test_glitch();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Monitors a multiplexed, active-low seven-segment display bus (digit anodes plus a shared segment bus).
- Converts each digit's segment pattern back to a BCD code, the inverse of our BCD-to-segment decoder.
- Assembles a multi-digit frame and publishes it with a one-cycle valid pulse once it has been stable for a set number of full scans.
- Used as a display loopback/self-check monitor and as the bench-facing reader for display drivers.

Parameters:
- DIGITS, 4: number of multiplexed digits; anode bit i maps to digit i, and digit 0 is least significant.
- SETTLE, 2: consecutive cycles an anode must be held before its segments are captured (≥1).
- STABLE_SCANS, 2: consecutive identical complete frames required before publishing (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- an  in  DIGITS  digit enables, active-low; exactly one low bit selects a digit.
- seg  in  7  segments, active-low; bit6=a, bit5=b … bit0=g.
- bcd_out  out  4*DIGITS  published frame; digit i is at [4i+3:4i].
- err_out  out  DIGITS  per-digit invalid-pattern flag for the published frame.
- out_valid  out  1  one-cycle pulse when bcd_out/err_out update.

Behaviour:
- One clock; reset is synchronous and active-high on rst.
- Reset clears:
  - bcd_out=0, err_out=0, out_valid=0;
  - capture mask, settle counter, working frame, previous frame, stable count;
  - the "published" flag.
- Pattern map (seg, active-low → code):
  - 0=7'h01, 1=7'h4F, 2=7'h12, 3=7'h06, 4=7'h4C, 5=7'h24, 6=7'h20, 7=7'h0F, 8=7'h00, 9=7'h04.
  - Blank 7'h7F → 4'hA, err=0.
  - Any other pattern → 4'hF, err=1.
- Settle counter:
  - Increments while an is one-hot-low and equal to its previous-cycle value.
  - Resets to 0 on any change of an, or when an is not one-hot (all high or multiple low). Non-one-hot cycles never capture.
- Capture:
  - Occurs in the cycle the counter reaches SETTLE-1, exactly once per dwell.
  - Writes the code and error bit for that digit and sets its mask bit.
  - A repeat capture of the same digit within a frame overwrites it; no error is raised.
- Frame complete:
  - Registered the cycle after the mask becomes all ones.
  - The evaluation cycle clears the mask.
  - A capture landing in the evaluation cycle belongs to the next frame.
- Stability:
  - On frame complete, if frame (codes and err bits) equals the previous frame, stable_cnt = min(stable_cnt+1, STABLE_SCANS). Otherwise stable_cnt=1.
  - The previous frame is then updated.
  - After reset there is no previous frame, so the first frame always gives stable_cnt=1.
- Publish:
  - Happens when the updated stable_cnt == STABLE_SCANS and (the published flag is clear, or the frame differs from bcd_out/err_out).
  - bcd_out, err_out and out_valid all update together.
  - Latency: final capture at cycle N, evaluation at N+1, out_valid high at N+2.
  - out_valid is never high in two consecutive cycles.
- Publishing is not gated by errors; err_out reports them.
- rst mid-scan discards partial frames and stability history. Publishing again needs STABLE_SCANS fresh complete frames.

Decomposition:
- Package seg7_pkg holds:
  - the ten digit segment constants and the SEG_BLANK constant;
  - CODE_BLANK=4'hA and CODE_INVALID=4'hF;
  - the segment bit-order definition.
  It is shared with the existing BCD-to-segment decoder.
- One combinational sub-module, seg7_pattern_to_bcd: input seg[6:0], outputs code[3:0] and err. Instantiate it once on the live bus.

Test Plan:
- Reset: rst high for 3 cycles with random an/seg → bcd_out=0, err_out=0, out_valid=0 throughout and one cycle after release.
- Stable value (DIGITS=4, SETTLE=2, STABLE_SCANS=2, 4-cycle dwell):
  - Scan digits 3..0 = 7'h4F,7'h12,7'h06,7'h4C twice → exactly one out_valid, 2 cycles after the second scan's last capture, with bcd_out=16'h1234 and err_out=0.
  - A third identical scan → no pulse.
- Transient value: after 1234 is published, one scan of 5678 (7'h24,7'h20,7'h0F,7'h00), then 1234 scans → no out_valid at any point; bcd_out stays 16'h1234.
- Invalid/blank: digit2=7'h7E and digit0=7'h7F with digits 3,1 = 7'h04 for two scans → bcd_out=16'h9F9A and err_out=4'b0100.
- Glitch rejection:
  - 1-cycle dwells on each anode → no captures and no pulse.
  - an=4'b0000 and an=4'b1111 are ignored; a subsequent valid scan still needs two full frames.
- Mid-scan reset: one full scan of 1234, then rst asserted after digits 3 and 2 of the second scan → no pulse; the next two full scans publish 16'h1234.
